// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: the five channels between one master and one slave.
interface axi_lite_if #(
  parameter int AXI_LITE_ADDR_WIDTH = 8
);
  logic [AXI_LITE_ADDR_WIDTH-1:0] awaddr;
  logic                           awvalid;
  logic                           awready;
  logic [31:0]                    wdata;
  logic [3:0]                     wstrb;
  logic                           wvalid;
  logic                           wready;
  logic [1:0]                     bresp;
  logic                           bvalid;
  logic                           bready;
  logic [AXI_LITE_ADDR_WIDTH-1:0] araddr;
  logic                           arvalid;
  logic                           arready;
  logic [31:0]                    rdata;
  logic [1:0]                     rresp;
  logic                           rvalid;
  logic                           rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one bus
// transaction and returns a response; misaligned addresses fail locally.
module axi_lite_master #(
  parameter int AXI_LITE_ADDR_WIDTH = 8
) (
  input  logic                           m_axi_lite_aclk,
  input  logic                           axi_resetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                    cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic [1:0]                     rsp_resp,
  axi_lite_if.master                     m_axi_lite
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RESP
  } state_e;

  state_e                         state_q, state_d;
  logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic [31:0]                    rdata_q, rdata_d;
  logic [1:0]                     resp_q, resp_d;
  logic                           aw_done_q, aw_done_d;
  logic                           w_done_q, w_done_d;

  always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rdata_d = '0;
          if (cmd_addr[1:0] != 2'b00) begin
            resp_d  = RESP_SLVERR;
            state_d = ST_RESP;
          end else if (cmd_write) begin
            wdata_d   = cmd_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WRITE;
          end else begin
            state_d = ST_RADDR;
          end
        end
      end
      // AW and W complete independently; a channel already done ignores its ready.
      ST_WRITE: begin
        aw_done_d = aw_done_q | m_axi_lite.awready;
        w_done_d  = w_done_q | m_axi_lite.wready;
        if (aw_done_d && w_done_d) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (m_axi_lite.bvalid) begin
          resp_d  = m_axi_lite.bresp;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RADDR: begin
        if (m_axi_lite.arready) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi_lite.rvalid) begin
          rdata_d = m_axi_lite.rdata;
          resp_d  = m_axi_lite.rresp;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode straight from registered state, so reset clears them at once.
  assign cmd_ready          = (state_q == ST_IDLE);
  assign rsp_valid          = (state_q == ST_RESP);
  assign rsp_rdata          = rdata_q;
  assign rsp_resp           = resp_q;

  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.awvalid = (state_q == ST_WRITE) && !aw_done_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = 4'hF;
  assign m_axi_lite.wvalid  = (state_q == ST_WRITE) && !w_done_q;
  assign m_axi_lite.bready  = (state_q == ST_WRESP);
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.arvalid = (state_q == ST_RADDR);
  assign m_axi_lite.rready  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-configurable memory slave, directed and
// random commands checked against a word-memory response model.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  always #5 clk = ~clk;

  axi_lite_if #(.AXI_LITE_ADDR_WIDTH(8)) bus ();

  axi_lite_master #(.AXI_LITE_ADDR_WIDTH(8)) dut (
    .m_axi_lite_aclk (clk),
    .axi_resetn      (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_resp        (rsp_resp),
    .m_axi_lite      (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Slave configuration (written by the stimulus, read by the slave)
  int         cfg_aw, cfg_w, cfg_ar, cfg_b, cfg_r;
  logic [1:0] cfg_resp;

  // Slave-owned state and observation counters
  logic [31:0] slave_mem [64];
  int          aw_beats = 0, w_beats = 0, ar_beats = 0, valid_cycles = 0, proto_err = 0;
  logic [7:0]  last_awaddr, last_araddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  initial begin : slave
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit aw_act, w_act, ar_act, aw_got, w_got, b_pend, b_fired, r_pend, r_fired;
    bit p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
    logic [7:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata, b_data, r_data;
    logic [5:0]  b_idx;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    b_data = '0; r_data = '0; b_idx = '0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0;
    for (int i = 0; i < 64; i++) slave_mem[i] = init_word(i);
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.bvalid = 0; bus.rvalid = 0;
        aw_act = 0; w_act = 0; ar_act = 0; aw_got = 0; w_got = 0;
        b_pend = 0; b_fired = 0; r_pend = 0; r_fired = 0;
        p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
        continue;
      end
      // A pending valid must persist with stable payload until its handshake
      if (p_awv && !p_awhs && (!bus.awvalid || bus.awaddr != p_awaddr)) proto_err++;
      if (p_wv  && !p_whs  && (!bus.wvalid  || bus.wdata  != p_wdata))  proto_err++;
      if (p_arv && !p_arhs && (!bus.arvalid || bus.araddr != p_araddr)) proto_err++;
      if (bus.awvalid || bus.wvalid || bus.arvalid) valid_cycles++;

      if (b_fired) begin bus.bvalid = 0; b_fired = 0; end
      if (b_pend) begin
        if (b_wait > 0) b_wait--;
        else begin
          bus.bvalid = 1; bus.bresp = cfg_resp;
          if (bus.bready) begin b_fired = 1; b_pend = 0; slave_mem[b_idx] = b_data; end
        end
      end
      if (r_fired) begin bus.rvalid = 0; r_fired = 0; end
      if (r_pend) begin
        if (r_wait > 0) r_wait--;
        else begin
          bus.rvalid = 1; bus.rresp = cfg_resp; bus.rdata = r_data;
          if (bus.rready) begin r_fired = 1; r_pend = 0; end
        end
      end

      bus.awready = 0;
      if (bus.awvalid) begin
        if (!aw_act) begin aw_act = 1; aw_wait = cfg_aw; end
        if (aw_wait > 0) aw_wait--;
        else begin
          bus.awready = 1; aw_act = 0; aw_beats++; last_awaddr = bus.awaddr; aw_got = 1;
        end
      end
      bus.wready = 0;
      if (bus.wvalid) begin
        if (!w_act) begin w_act = 1; w_wait = cfg_w; end
        if (w_wait > 0) w_wait--;
        else begin
          bus.wready = 1; w_act = 0; w_beats++;
          last_wdata = bus.wdata; last_wstrb = bus.wstrb; w_got = 1;
        end
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = cfg_b;
        b_idx = last_awaddr[7:2]; b_data = last_wdata;
      end
      bus.arready = 0;
      if (bus.arvalid) begin
        if (!ar_act) begin ar_act = 1; ar_wait = cfg_ar; end
        if (ar_wait > 0) ar_wait--;
        else begin
          bus.arready = 1; ar_act = 0; ar_beats++; last_araddr = bus.araddr;
          r_pend = 1; r_wait = cfg_r; r_data = slave_mem[bus.araddr[7:2]];
        end
      end

      p_awv = bus.awvalid; p_awhs = bus.awready; p_awaddr = bus.awaddr;
      p_wv  = bus.wvalid;  p_whs  = bus.wready;  p_wdata  = bus.wdata;
      p_arv = bus.arvalid; p_arhs = bus.arready; p_araddr = bus.araddr;
    end
  end

  // Reference model: word memory plus response/latency rules
  logic [31:0] model_mem [64];

  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int d_aw, input int d_w, input int d_ar, input int d_b,
                         input int d_r, input logic [1:0] sresp, input int hold);
    bit          mis, stable;
    logic [1:0]  e_resp, resp_got;
    logic [31:0] e_rdata, r_got;
    int          e_lat, lat, waitc, aw0, w0, ar0, vc0, pe0;
    mis     = (addr[1:0] != 2'b00);
    e_resp  = mis ? 2'b10 : sresp;
    e_rdata = (mis || wr) ? 32'h0 : model_mem[addr[7:2]];
    if (mis)     e_lat = 1;
    else if (wr) e_lat = 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
    else         e_lat = 3 + d_ar + d_r;
    cfg_aw = d_aw; cfg_w = d_w; cfg_ar = d_ar; cfg_b = d_b; cfg_r = d_r; cfg_resp = sresp;
    aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats; vc0 = valid_cycles; pe0 = proto_err;

    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    waitc = 0;
    while (!cmd_ready && waitc < 50) begin @(negedge clk); waitc++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 0;

    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
    r_got = rsp_rdata; resp_got = rsp_resp; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== r_got || rsp_resp !== resp_got || cmd_ready) stable = 0;
    end
    if (hold > 0) chk("rsp_stable", 32'(stable), 32'd1);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);

    chk("rsp_rdata", r_got, e_rdata);
    chk("rsp_resp", 32'(resp_got), 32'(e_resp));
    chk("aw_beats", 32'(aw_beats - aw0), (wr && !mis) ? 32'd1 : 32'd0);
    chk("w_beats", 32'(w_beats - w0), (wr && !mis) ? 32'd1 : 32'd0);
    chk("ar_beats", 32'(ar_beats - ar0), (!wr && !mis) ? 32'd1 : 32'd0);
    if (mis) chk("no_bus_valid", 32'(valid_cycles - vc0), 32'd0);
    else if (wr) begin
      chk("awaddr", 32'(last_awaddr), 32'(addr));
      chk("wdata", last_wdata, wd);
      chk("wstrb", 32'(last_wstrb), 32'hF);
    end else chk("araddr", 32'(last_araddr), 32'(addr));
    chk("protocol", 32'(proto_err - pe0), 32'd0);
    if (wr && !mis) model_mem[addr[7:2]] = wd;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         waitc;
    bit         seen;
    bit         wr;
    logic [7:0] a;
    rst_n = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_b = 0; cfg_r = 0; cfg_resp = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);

    #2 rst_n = 0;
    #1;
    chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("rst_awaddr", 32'(bus.awaddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);

    // Directed scenarios
    run_txn(1, 8'h08, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1, 8'h20, 32'h0BAD_F00D, 3, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1, 8'h5C, 32'hE8BB41B8, 0, 2, 0, 1, 0, 2'b00, 0);
    run_txn(0, 8'h5C, 32'h0, 0, 0, 2, 0, 0, 2'b00, 0);
    run_txn(0, 8'h08, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(0, 8'h60, 32'h0, 0, 0, 0, 0, 1, 2'b10, 0);
    run_txn(0, 8'h06, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1, 8'h07, 32'h1111_2222, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1, 8'h30, 32'hCAFE_0001, 1, 1, 0, 0, 0, 2'b11, 5);
    run_txn(0, 8'h30, 32'h0, 0, 0, 0, 0, 0, 2'b00, 5);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(wr, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    // Reset while waiting for the write response
    cfg_aw = 0; cfg_w = 0; cfg_b = 8; cfg_resp = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h10; cmd_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 cmd_valid = 0;
    waitc = 0;
    while (!bus.bready && waitc < 20) begin @(negedge clk); waitc++; end
    chk("reach_wresp", 32'(bus.bready), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("rsp_rdata_after_reset", rsp_rdata, 32'd0);
    run_txn(0, 8'h10, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1, 8'h10, 32'hA5A5_5A5A, 0, 0, 0, 0, 0, 2'b00, 0);
    run_txn(0, 8'h10, 32'h0, 0, 0, 1, 0, 2, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
